sbox_sched: RTL and testbench

SBOX_SCHED -- requirements
Module: sbox_sched

---
 rtl/aes_pkg.sv | 13 +
 rtl/s_box.sv | 29 ++
 rtl/sbox_sched.sv | 131 +++++++++++++
 tb/tb_sbox_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: scheduler state encoding and lane/beat geometry.
package aes_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned NUM_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SB_RUN = 2'd1,
    KW_RUN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/s_box.sv
// AES forward S-box: combinational byte substitution by table lookup.
module s_box (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Byte 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = TABLE[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/sbox_sched.sv
// Time-shares four S-box lanes between a 16-byte SubBytes requester (4 beats)
// and a 32-bit key-expansion SubWord requester (1 beat), with round-robin arbitration.
module sbox_sched
  import aes_pkg::*;
#(
  parameter logic PRIO_KEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sb_valid,
  output logic         sb_ready,
  input  logic [127:0] sb_data,
  output logic         sb_done,
  output logic [127:0] sb_result,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_word,
  output logic         kw_done,
  output logic [31:0]  kw_result
);

  localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

  sched_state_t r_state;
  sched_state_t w_next;
  logic [1:0]   r_beat;
  logic [127:0] r_sb_data;
  logic [95:0]  r_sb_work;
  logic [127:0] r_sb_result;
  logic [31:0]  r_kw_data;
  logic [31:0]  r_kw_result;
  logic         r_sb_done;
  logic         r_kw_done;
  logic         r_last_kw;
  logic         w_sb_grant;
  logic         w_kw_grant;
  logic [31:0]  w_sb_word;
  logic [31:0]  w_src_word;
  logic [31:0]  w_lane_word;

  always_comb begin
    w_next   = r_state;
    sb_ready = 1'b0;
    kw_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the requester that was not granted last wins.
        sb_ready = !kw_valid || r_last_kw;
        kw_ready = !sb_valid || !r_last_kw;
        if (kw_valid && kw_ready)      w_next = KW_RUN;
        else if (sb_valid && sb_ready) w_next = SB_RUN;
      end
      SB_RUN:  if (r_beat == LAST_BEAT) w_next = IDLE;
      KW_RUN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_sb_grant = sb_valid && sb_ready;
  assign w_kw_grant = kw_valid && kw_ready;

  always_comb begin
    w_sb_word = r_sb_data[127:96];
    case (r_beat)
      2'd1:    w_sb_word = r_sb_data[95:64];
      2'd2:    w_sb_word = r_sb_data[63:32];
      2'd3:    w_sb_word = r_sb_data[31:0];
      default: w_sb_word = r_sb_data[127:96];
    endcase
  end

  assign w_src_word = (r_state == KW_RUN) ? r_kw_data : w_sb_word;

  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
    s_box u_s_box (
      .i_byte (w_src_word[8*(int'(NUM_LANES)-1-g) +: 8]),
      .o_byte (w_lane_word[8*(int'(NUM_LANES)-1-g) +: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_sb_data   <= '0;
      r_sb_work   <= '0;
      r_sb_result <= '0;
      r_kw_data   <= '0;
      r_kw_result <= '0;
      r_sb_done   <= 1'b0;
      r_kw_done   <= 1'b0;
      r_last_kw   <= ~PRIO_KEY;
    end else begin
      r_state   <= w_next;
      r_sb_done <= 1'b0;
      r_kw_done <= 1'b0;
      if (w_sb_grant) begin
        r_sb_data <= sb_data;
        r_beat    <= '0;
        r_last_kw <= 1'b0;
      end
      if (w_kw_grant) begin
        r_kw_data <= kw_word;
        r_last_kw <= 1'b1;
      end
      // Beats 0..2 fill a scratch buffer so sb_result only changes with sb_done.
      if (r_state == SB_RUN) begin
        r_beat <= r_beat + 2'd1;
        case (r_beat)
          2'd0: r_sb_work[95:64] <= w_lane_word;
          2'd1: r_sb_work[63:32] <= w_lane_word;
          2'd2: r_sb_work[31:0]  <= w_lane_word;
          default: begin
            r_sb_result <= {r_sb_work, w_lane_word};
            r_sb_done   <= 1'b1;
          end
        endcase
      end
      if (r_state == KW_RUN) begin
        r_kw_result <= w_lane_word;
        r_kw_done   <= 1'b1;
      end
    end
  end

  assign sb_done   = r_sb_done;
  assign sb_result = r_sb_result;
  assign kw_done   = r_kw_done;
  assign kw_result = r_kw_result;

endmodule

// File: tb/tb_sbox_sched.sv
// Self-checking bench for sbox_sched: directed vectors, reset abort, and a
// cycle-level reference model driven by random request traffic.
module tb_sbox_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         sb_valid, sb_ready, sb_done;
  logic [127:0] sb_data, sb_result;
  logic         kw_valid, kw_ready, kw_done;
  logic [31:0]  kw_word, kw_result;

  always #5 clk = ~clk;

  sbox_sched #(.PRIO_KEY(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .sb_valid  (sb_valid),
    .sb_ready  (sb_ready),
    .sb_data   (sb_data),
    .sb_done   (sb_done),
    .sb_result (sb_result),
    .kw_valid  (kw_valid),
    .kw_ready  (kw_ready),
    .kw_word   (kw_word),
    .kw_done   (kw_done),
    .kw_result (kw_result)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   ref_tab [256];
  int           m_free_at, m_sb_done_at, m_kw_done_at;
  bit           m_last_kw;
  logic [127:0] m_sb_res, m_sb_pend;
  logic [31:0]  m_kw_res, m_kw_pend;
  int           grants[$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox_def(input logic [7:0] x);
    logic [7:0] inv = '0;
    for (int k = 1; k < 256; k++)
      if (gmul(x, 8'(k)) == 8'h01) inv = 8'(k);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_free_at    = cyc;
    m_sb_done_at = -1;
    m_kw_done_at = -1;
    m_last_kw    = 1'b0;
    m_sb_res     = '0;
    m_kw_res     = '0;
  endtask

  task automatic do_sb(input logic [127:0] d, input bit chg, input string tag);
    int n;
    sb_valid = 1'b1;
    sb_data  = d;
    kw_valid = 1'b0;
    #1;
    chk({tag, "_ready"}, sb_ready, 1'b1);
    m_sb_pend = sub128(d);
    m_last_kw = 1'b0;
    tick();
    sb_valid = 1'b0;
    if (chg) sb_data = ~d;
    n = 1;
    while (!sb_done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_result"}, sb_result, m_sb_pend);
    chk({tag, "_kwdone"}, kw_done, 1'b0);
    m_sb_res = m_sb_pend;
    tick();
    chk({tag, "_pulse"}, sb_done, 1'b0);
    chk({tag, "_hold"}, sb_result, m_sb_res);
  endtask

  task automatic do_kw(input logic [31:0] w, input string tag);
    int n;
    kw_valid = 1'b1;
    kw_word  = w;
    sb_valid = 1'b0;
    #1;
    chk({tag, "_ready"}, kw_ready, 1'b1);
    m_kw_pend = sub32(w);
    m_last_kw = 1'b1;
    tick();
    kw_valid = 1'b0;
    kw_word  = ~w;
    n = 1;
    while (!kw_done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_result"}, kw_result, m_kw_pend);
    chk({tag, "_sbkeep"}, sb_result, m_sb_res);
    m_kw_res = m_kw_pend;
    tick();
    chk({tag, "_pulse"}, kw_done, 1'b0);
  endtask

  // Cycle-level reference: one op in flight, done at accept+5 (SB) / accept+2 (KW).
  task automatic run_model(input int n, input bit both);
    bit idle, g_sb, g_kw;
    m_free_at    = cyc;
    m_sb_done_at = -1;
    m_kw_done_at = -1;
    sb_data = {$urandom, $urandom, $urandom, $urandom};
    kw_word = $urandom;
    for (int it = 0; it < n + 6; it++) begin
      if (cyc == m_sb_done_at) m_sb_res = m_sb_pend;
      if (cyc == m_kw_done_at) m_kw_res = m_kw_pend;
      chk("m_sb_done", sb_done, cyc == m_sb_done_at);
      chk("m_kw_done", kw_done, cyc == m_kw_done_at);
      chk("m_excl", sb_done & kw_done, 1'b0);
      chk("m_sb_result", sb_result, m_sb_res);
      chk("m_kw_result", kw_result, m_kw_res);
      if (it >= n) begin
        sb_valid = 1'b0;
        kw_valid = 1'b0;
      end else if (both) begin
        sb_valid = 1'b1;
        kw_valid = 1'b1;
      end else begin
        if (!sb_valid && $urandom_range(2) == 0) sb_valid = 1'b1;
        if (!kw_valid && $urandom_range(2) == 0) kw_valid = 1'b1;
      end
      #1;
      idle = (cyc >= m_free_at);
      g_sb = 1'b0;
      g_kw = 1'b0;
      if (!idle) begin
        chk("m_busy_sbrdy", sb_ready, 1'b0);
        chk("m_busy_kwrdy", kw_ready, 1'b0);
      end else if (sb_valid && kw_valid) begin
        g_kw = !m_last_kw;
        g_sb = m_last_kw;
        chk("m_tie_sbrdy", sb_ready, g_sb);
        chk("m_tie_kwrdy", kw_ready, g_kw);
      end else if (sb_valid) begin
        g_sb = 1'b1;
        chk("m_sbrdy", sb_ready, 1'b1);
      end else if (kw_valid) begin
        g_kw = 1'b1;
        chk("m_kwrdy", kw_ready, 1'b1);
      end
      if (g_sb) begin
        m_sb_pend    = sub128(sb_data);
        m_sb_done_at = cyc + 5;
        m_free_at    = cyc + 5;
        m_last_kw    = 1'b0;
        grants.push_back(0);
      end
      if (g_kw) begin
        m_kw_pend    = sub32(kw_word);
        m_kw_done_at = cyc + 2;
        m_free_at    = cyc + 2;
        m_last_kw    = 1'b1;
        grants.push_back(1);
      end
      tick();
      if (g_sb) begin
        sb_data = {$urandom, $urandom, $urandom, $urandom};
        if (!both && $urandom_range(1) == 0) sb_valid = 1'b0;
      end
      if (g_kw) begin
        kw_word = $urandom;
        if (!both && $urandom_range(1) == 0) kw_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_tab[i] = sbox_def(8'(i));
    rst      = 1'b1;
    sb_valid = 1'b1;
    kw_valid = 1'b1;
    sb_data  = '0;
    kw_word  = '0;
    tick();
    tick();
    chk("rst_sb_done", sb_done, 1'b0);
    chk("rst_kw_done", kw_done, 1'b0);
    chk("rst_sb_result", sb_result, '0);
    chk("rst_kw_result", kw_result, '0);
    chk("rst_kw_ready", kw_ready, 1'b1);
    chk("rst_sb_ready", sb_ready, 1'b0);
    sb_valid = 1'b0;
    kw_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();

    do_sb('0, 1'b0, "sb_zero");
    chk("sb_zero_const", sb_result, {16{8'h63}});
    do_sb(128'h000102030405060708090a0b0c0d0e0f, 1'b1, "sb_seq");
    chk("sb_seq_const", sb_result, 128'h637c777bf26b6fc53001672bfed7ab76);
    do_kw(32'h00010203, "kw_seq");
    chk("kw_seq_const", kw_result, 32'h637c777b);
    chk("kw_seq_sbconst", sb_result, 128'h637c777bf26b6fc53001672bfed7ab76);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    grants.delete();
    run_model(30, 1'b1);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < grants.size()) ? grants[i] : -1, (i % 2 == 0) ? 1 : 0);

    grants.delete();
    run_model(150, 1'b0);

    sb_valid = 1'b1;
    sb_data  = 128'h00112233445566778899aabbccddeeff;
    kw_valid = 1'b0;
    #1;
    chk("abort_ready", sb_ready, 1'b1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_sb_done", sb_done, 1'b0);
    chk("abort_sb_result", sb_result, '0);
    chk("abort_kw_result", kw_result, '0);
    tick();
    tick();
    chk("abort_no_done", sb_done, 1'b0);
    rst = 1'b0;
    model_reset();
    do_sb(128'h00112233445566778899aabbccddeeff, 1'b0, "sb_retry");
    chk("sb_retry_const", sb_result, 128'h638293c31bfc33f5c4eeacea4bc12816);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
